counter_checker: RTL
====================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 2, is the width of the monitored counter value.
REQ-002 Parameter LOCK_COUNT, default 2, is the number of consecutive correct increments required to declare lock (legal range 1..15).
REQ-003 Parameter ERR_CNT_WIDTH, default 8, is the width of the error counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 valid_in  input  1  counter_in carries a sample this cycle.
REQ-007 counter_in  input  WIDTH  sampled counter value from the counter under observation.
REQ-008 clear_err  input  1  synchronous clear of err_count and sticky_error.
REQ-009 locked  output  1  checker is locked to an incrementing sequence.
REQ-010 error  output  1  single-cycle pulse on a sequence mismatch while locked.
REQ-011 sticky_error  output  1  set by any error pulse; held until clear_err or reset.
REQ-012 err_count  output  ERR_CNT_WIDTH  number of errors since last clear, saturating.
REQ-013 expected  output  WIDTH  value the next valid sample must equal.
REQ-014 bad_value  output  WIDTH  counter_in captured at the most recent error.

Function
REQ-015 All outputs SHALL be registered; each reflects a sample on the clock edge after valid_in was high.
REQ-016 FSM states SHALL be IDLE, ACQUIRE, LOCKED; state advances only on edges with valid_in=1.
REQ-017 With valid_in=0, state, match count, expected, and all outputs SHALL hold, except that error deasserts and clear_err still acts.
REQ-018 IDLE + valid sample v -> ACQUIRE; expected <= v+1; match count <= 0.
REQ-019 expected SHALL be computed modulo 2^WIDTH (all-ones + 1 wraps to 0, and the wrap counts as a match).
REQ-020 ACQUIRE, sample == expected -> match count +1 and expected <= sample+1; when the count reaches LOCK_COUNT -> LOCKED, locked=1.
REQ-021 ACQUIRE, sample != expected -> stay in ACQUIRE, match count <= 0, expected <= sample+1, and no error is raised.
REQ-022 LOCKED, sample == expected -> stay in LOCKED and expected <= sample+1.
REQ-023 LOCKED, sample != expected -> error=1 for exactly one cycle, sticky_error=1, bad_value <= sample, err_count +1 (saturating at all-ones), locked=0, and the state goes to ACQUIRE with expected <= sample+1 and match count 0.
REQ-024 error SHALL be 0 in every cycle not described by REQ-023.
REQ-025 clear_err and an error event on the same edge -> the clear is applied first, then the increment, giving err_count=1 and sticky_error=1.
REQ-026 clear_err SHALL NOT affect state, locked, expected, or bad_value.
REQ-027 At saturation err_count SHALL hold all-ones; error and sticky_error still behave normally.

Reset
REQ-028 reset=0 SHALL immediately, without a clock, force state=IDLE, match count=0, and locked, error, sticky_error, err_count, expected, and bad_value all to 0.
REQ-029 Assertion mid-operation, including while LOCKED, SHALL discard all history; after release, the first valid sample re-enters ACQUIRE per REQ-018.
REQ-030 The deassertion edge SHALL be treated as synchronous: no sample is accepted on the edge coincident with release.

Verification (WIDTH=2, LOCK_COUNT=2, ERR_CNT_WIDTH=8)
REQ-031 Hold reset=0 for 3 cycles with valid_in=1 and toggling counter_in -> all outputs 0 throughout.
REQ-032 Valid samples 0,1,2 -> locked=1 one edge after sample 2; then samples 3,0,1 -> locked stays 1, error=0, expected=2.
REQ-033 Locked at expected=2, sample 0 -> one-cycle error, err_count=1, sticky_error=1, bad_value=0, locked=0; then samples 1,2 -> locked=1 again, sticky_error still 1.
REQ-034 While locked, insert valid_in=0 gaps of 1 and 5 cycles with counter_in garbage between correct samples -> no error, locked=1.
REQ-035 Force 256 errors -> err_count=255 and held; then clear_err coincident with a mismatch -> err_count=1, sticky_error=1.
REQ-036 Drop reset to 0 between clock edges while locked -> outputs 0 before the next edge; release, then samples 3,0,1 -> locked=1.

Source files
------------

// File: rtl/counter_checker.sv
// Sequence checker for a free-running counter: locks after a run of correct
// increments, then flags, counts and captures any sample that breaks the run.
module counter_checker #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned LOCK_COUNT    = 2,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         counter_in,
  input  logic                     clear_err,
  output logic                     locked,
  output logic                     error,
  output logic                     sticky_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]         expected,
  output logic [WIDTH-1:0]         bad_value
);

  localparam int unsigned MATCH_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                     state, state_d;
  logic [MATCH_W-1:0]         match_cnt, match_cnt_d;
  logic                       armed;
  logic                       locked_d, error_d, sticky_d;
  logic [ERR_CNT_WIDTH-1:0]   err_count_d;
  logic [WIDTH-1:0]           expected_d, bad_value_d;

  // Gates sample acceptance so the edge coincident with reset release is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      match_cnt    <= '0;
      locked       <= 1'b0;
      error        <= 1'b0;
      sticky_error <= 1'b0;
      err_count    <= '0;
      expected     <= '0;
      bad_value    <= '0;
    end else begin
      state        <= state_d;
      match_cnt    <= match_cnt_d;
      locked       <= locked_d;
      error        <= error_d;
      sticky_error <= sticky_d;
      err_count    <= err_count_d;
      expected     <= expected_d;
      bad_value    <= bad_value_d;
    end
  end

  always_comb begin
    logic [WIDTH-1:0]         sample_inc;
    logic [MATCH_W-1:0]       match_inc;
    logic [ERR_CNT_WIDTH-1:0] err_base;
    logic                     err_event;

    state_d     = state;
    match_cnt_d = match_cnt;
    expected_d  = expected;
    bad_value_d = bad_value;
    err_event   = 1'b0;
    sample_inc  = counter_in + WIDTH'(1);
    match_inc   = match_cnt + MATCH_W'(1);

    if (valid_in && armed) begin
      unique case (state)
        IDLE: begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
          expected_d  = sample_inc;
        end
        ACQUIRE: begin
          expected_d = sample_inc;
          if (counter_in == expected) begin
            match_cnt_d = match_inc;
            if (match_inc >= MATCH_W'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          expected_d = sample_inc;
          if (counter_in != expected) begin
            err_event   = 1'b1;
            bad_value_d = counter_in;
            state_d     = ACQUIRE;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d     = IDLE;
          match_cnt_d = '0;
        end
      endcase
    end

    // Clear lands before the increment so a coincident error leaves a count of one
    err_base = clear_err ? '0 : err_count;
    if (err_event && (err_base != '1)) err_count_d = err_base + ERR_CNT_WIDTH'(1);
    else                               err_count_d = err_base;

    if (err_event)      sticky_d = 1'b1;
    else if (clear_err) sticky_d = 1'b0;
    else                sticky_d = sticky_error;

    error_d  = err_event;
    locked_d = (state_d == LOCKED);
  end

endmodule
